// File: rtl/multi_timer.sv
// N-channel interval timer: per-channel programmable period, periodic or one-shot
// mode, start/stop control, registered tick pulse plus busy/done status.
module multi_timer #(
  parameter int unsigned NUM_CH         = 3,
  parameter int unsigned WIDTH          = 20,
  parameter int unsigned DEFAULT_PERIOD = 1000
) (
  input  logic                                              i_clk,
  input  logic                                              i_rst,
  input  logic [NUM_CH-1:0]                                 i_start,
  input  logic [NUM_CH-1:0]                                 i_stop,
  input  logic [NUM_CH-1:0]                                 i_oneshot,
  input  logic                                              i_wr,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]    i_wr_ch,
  input  logic [WIDTH-1:0]                                  i_wr_period,
  output logic [NUM_CH-1:0]                                 o_tick,
  output logic [NUM_CH-1:0]                                 o_busy,
  output logic [NUM_CH-1:0]                                 o_done
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q   [NUM_CH];
  state_e           state_d   [NUM_CH];
  logic [WIDTH-1:0] cnt_q     [NUM_CH];
  logic [WIDTH-1:0] cnt_d     [NUM_CH];
  logic [WIDTH-1:0] period_q  [NUM_CH];
  logic [WIDTH-1:0] period_d  [NUM_CH];
  logic [WIDTH-1:0] pending_q [NUM_CH];
  logic [WIDTH-1:0] pending_d [NUM_CH];
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] busy_q, busy_d;
  logic [NUM_CH-1:0] done_q, done_d;

  logic [WIDTH-1:0]  eff_c [NUM_CH];
  logic [NUM_CH-1:0] term_c;
  logic [NUM_CH-1:0] wr_hit_c;

  // Effective period (0 behaves as 1), terminal-count and write-select decode.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      eff_c[c]    = (period_q[c] == '0) ? WIDTH'(1) : period_q[c];
      term_c[c]   = (cnt_q[c] == (eff_c[c] - WIDTH'(1)));
      wr_hit_c[c] = i_wr && (i_wr_ch == CH_W'(c));
    end
  end

  // Per-channel next state: stop beats start beats counting.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    pending_d = pending_q;
    mode_d    = mode_q;
    tick_d    = '0;
    busy_d    = busy_q;
    done_d    = done_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_hit_c[c]) begin
        pending_d[c] = i_wr_period;
      end
      if (i_stop[c]) begin
        state_d[c] = ST_IDLE;
        cnt_d[c]   = '0;
        busy_d[c]  = 1'b0;
        done_d[c]  = 1'b0;
      end else if (i_start[c]) begin
        state_d[c]  = ST_RUN;
        cnt_d[c]    = '0;
        mode_d[c]   = i_oneshot[c];
        period_d[c] = pending_d[c];
        busy_d[c]   = 1'b1;
        done_d[c]   = 1'b0;
      end else if (state_q[c] == ST_RUN) begin
        if (term_c[c]) begin
          tick_d[c] = 1'b1;
          cnt_d[c]  = '0;
          if (mode_q[c]) begin
            state_d[c] = ST_DONE;
            busy_d[c]  = 1'b0;
            done_d[c]  = 1'b1;
          end else begin
            period_d[c] = pending_d[c];
          end
        end else begin
          cnt_d[c] = cnt_q[c] + WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c]   <= ST_IDLE;
        cnt_q[c]     <= '0;
        period_q[c]  <= WIDTH'(DEFAULT_PERIOD);
        pending_q[c] <= WIDTH'(DEFAULT_PERIOD);
      end
      mode_q <= '0;
      tick_q <= '0;
      busy_q <= '0;
      done_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      tick_q    <= tick_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_tick = tick_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: deadline-based reference model checked every cycle,
// plus directed scenarios with hand-computed tick/busy/done expectations.
module tb_multi_timer;

  localparam int NCH = 3;
  localparam int W   = 8;
  localparam int DEF = 10;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic [NCH-1:0] i_start, i_stop, i_oneshot;
  logic           i_wr;
  logic [1:0]     i_wr_ch;
  logic [W-1:0]   i_wr_period;
  logic [NCH-1:0] o_tick, o_busy, o_done;

  int checks = 0;
  int errors = 0;

  multi_timer #(.NUM_CH(NCH), .WIDTH(W), .DEFAULT_PERIOD(DEF)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
    .i_oneshot(i_oneshot), .i_wr(i_wr), .i_wr_ch(i_wr_ch),
    .i_wr_period(i_wr_period), .o_tick(o_tick), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: each running channel holds the absolute edge of its next expiry.
  int          cyc = 0;
  bit          model_valid = 1'b0;
  bit          m_run [NCH];
  bit          m_done[NCH];
  bit          m_os  [NCH];
  bit          m_tick[NCH];
  int unsigned m_pend[NCH];
  int unsigned m_per [NCH];
  int          m_deadline[NCH];
  int unsigned pn;

  function automatic int eff_of(int unsigned p);
    return (p == 0) ? 1 : int'(p);
  endfunction

  always @(posedge i_clk) begin
    cyc++;
    for (int c = 0; c < NCH; c++) begin
      if (i_rst) begin
        m_run[c] = 0; m_done[c] = 0; m_os[c] = 0; m_tick[c] = 0;
        m_pend[c] = DEF; m_per[c] = DEF; m_deadline[c] = 0;
      end else begin
        pn = m_pend[c];
        if (i_wr && int'(i_wr_ch) == c) pn = i_wr_period;
        m_tick[c] = 0;
        if (i_stop[c]) begin
          m_run[c] = 0; m_done[c] = 0;
        end else if (i_start[c]) begin
          m_run[c] = 1; m_done[c] = 0; m_os[c] = i_oneshot[c];
          m_per[c] = pn; m_deadline[c] = cyc + eff_of(pn);
        end else if (m_run[c] && cyc == m_deadline[c]) begin
          m_tick[c] = 1;
          if (m_os[c]) begin
            m_run[c] = 0; m_done[c] = 1;
          end else begin
            m_per[c] = pn; m_deadline[c] = cyc + eff_of(pn);
          end
        end
        m_pend[c] = pn;
      end
    end
    model_valid = 1'b1;
  end

  logic [NCH-1:0] e_tick, e_busy, e_done;
  always @(negedge i_clk) begin
    if (model_valid) begin
      for (int c = 0; c < NCH; c++) begin
        e_tick[c] = m_tick[c];
        e_busy[c] = m_run[c];
        e_done[c] = m_done[c];
      end
      checks += 3;
      if (o_tick !== e_tick) begin
        errors++;
        $display("FAIL model_tick cyc=%0d got=%b exp=%b", cyc, o_tick, e_tick);
      end
      if (o_busy !== e_busy) begin
        errors++;
        $display("FAIL model_busy cyc=%0d got=%b exp=%b", cyc, o_busy, e_busy);
      end
      if (o_done !== e_done) begin
        errors++;
        $display("FAIL model_done cyc=%0d got=%b exp=%b", cyc, o_done, e_done);
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, act, exp);
    end
  endtask

  task automatic chk3(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, act, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  initial begin
    i_rst = 1'b1; i_start = '0; i_stop = '0; i_oneshot = '0;
    i_wr = 1'b0; i_wr_ch = '0; i_wr_period = '0;
    adv(2);
    chk3("reset_tick", o_tick, 3'b000);
    chk3("reset_busy", o_busy, 3'b000);
    chk3("reset_done", o_done, 3'b000);
    i_rst = 1'b0;
    adv(1);

    // Periodic ch0 at default period 10.
    i_start[0] = 1'b1; adv(1); i_start[0] = 1'b0;
    chk("t1_busy_p0", o_busy[0], 1'b1);
    chk("t1_tick_p0", o_tick[0], 1'b0);
    adv(9);  chk("t1_tick_p9",  o_tick[0], 1'b0);
    adv(1);  chk("t1_tick_p10", o_tick[0], 1'b1);
    adv(1);  chk("t1_tick_p11", o_tick[0], 1'b0);
    adv(9);  chk("t1_tick_p20", o_tick[0], 1'b1);

    // One-shot ch1, period 4 written in the start cycle.
    i_wr = 1'b1; i_wr_ch = 2'd1; i_wr_period = 8'd4;
    i_start[1] = 1'b1; i_oneshot[1] = 1'b1;
    adv(1);
    i_wr = 1'b0; i_start[1] = 1'b0; i_oneshot[1] = 1'b0;
    adv(3);  chk("t2_tick_p3", o_tick[1], 1'b0);
             chk("t2_busy_p3", o_busy[1], 1'b1);
    adv(1);  chk("t2_tick_p4", o_tick[1], 1'b1);
             chk("t2_done_p4", o_done[1], 1'b1);
             chk("t2_busy_p4", o_busy[1], 1'b0);
    adv(1);  chk("t2_tick_p5", o_tick[1], 1'b0);
    adv(5);  chk("t2_done_p10", o_done[1], 1'b1);

    // Period write to running ch0 only takes effect at the wrap.
    i_stop[0] = 1'b1; adv(1); i_stop[0] = 1'b0;
    chk("t3_busy_stop", o_busy[0], 1'b0);
    i_start[0] = 1'b1; adv(1); i_start[0] = 1'b0;
    adv(2);
    i_wr = 1'b1; i_wr_ch = 2'd0; i_wr_period = 8'd5;
    adv(1); i_wr = 1'b0;
    adv(7);  chk("t3_tick_p10", o_tick[0], 1'b1);
    adv(4);  chk("t3_tick_p14", o_tick[0], 1'b0);
    adv(1);  chk("t3_tick_p15", o_tick[0], 1'b1);
    adv(5);  chk("t3_tick_p20", o_tick[0], 1'b1);

    // Restart of ch1 clears done.
    i_start[1] = 1'b1; adv(1); i_start[1] = 1'b0;
    chk("t2_done_clr", o_done[1], 1'b0);
    chk("t2_busy_rst", o_busy[1], 1'b1);
    i_stop[1] = 1'b1; adv(1); i_stop[1] = 1'b0;

    // Start+stop together on ch2, then stop one cycle before expiry.
    i_start[2] = 1'b1; i_stop[2] = 1'b1; adv(1);
    i_start[2] = 1'b0; i_stop[2] = 1'b0;
    chk("t4_busy_both", o_busy[2], 1'b0);
    adv(10); chk("t4_tick_both", o_tick[2], 1'b0);
    i_start[2] = 1'b1; adv(1); i_start[2] = 1'b0;
    adv(8);
    i_stop[2] = 1'b1; adv(1); i_stop[2] = 1'b0;
    chk("t4_busy_stop", o_busy[2], 1'b0);
    adv(1);  chk("t4_tick_p10", o_tick[2], 1'b0);

    // Period 0 on ch2 and 1 on ch1: tick every cycle; out-of-range write ignored.
    i_wr = 1'b1; i_wr_ch = 2'd2; i_wr_period = 8'd0; adv(1);
    i_wr_ch = 2'd1; i_wr_period = 8'd1; adv(1);
    i_wr = 1'b0;
    i_start[1] = 1'b1; i_start[2] = 1'b1; adv(1);
    i_start[1] = 1'b0; i_start[2] = 1'b0;
    adv(1);  chk3("t5_tick_p1", o_tick & 3'b110, 3'b110);
    adv(1);  chk3("t5_tick_p2", o_tick & 3'b110, 3'b110);
    i_wr = 1'b1; i_wr_ch = 2'd3; i_wr_period = 8'd7; adv(1); i_wr = 1'b0;
    chk3("t5_tick_p3", o_tick & 3'b110, 3'b110);
    adv(3);  chk3("t5_tick_p6", o_tick & 3'b110, 3'b110);
    i_stop[1] = 1'b1; i_stop[2] = 1'b1; adv(1);
    i_stop[1] = 1'b0; i_stop[2] = 1'b0;
    chk3("t5_tick_stop", o_tick & 3'b110, 3'b000);

    // Reset mid-count on ch0 restores default period and suppresses the tick.
    i_stop[0] = 1'b1; adv(1); i_stop[0] = 1'b0;
    i_start[0] = 1'b1; adv(1); i_start[0] = 1'b0;
    adv(6);
    i_rst = 1'b1; adv(1); i_rst = 1'b0;
    chk3("t6_tick_rst", o_tick, 3'b000);
    chk3("t6_busy_rst", o_busy, 3'b000);
    chk3("t6_done_rst", o_done, 3'b000);
    adv(3);  chk("t6_tick_p10", o_tick[0], 1'b0);
    i_start[0] = 1'b1; adv(1); i_start[0] = 1'b0;
    adv(5);  chk("t6_tick_p5",  o_tick[0], 1'b0);
    adv(5);  chk("t6_tick_p10b", o_tick[0], 1'b1);

    // Restart exactly at terminal count discards the expiry.
    adv(9);
    i_start[0] = 1'b1; adv(1); i_start[0] = 1'b0;
    chk("t7_tick_restart", o_tick[0], 1'b0);
    chk("t7_busy_restart", o_busy[0], 1'b1);
    adv(10); chk("t7_tick_p10", o_tick[0], 1'b1);

    adv(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
